// File: rtl/matrix_uart_link.sv
`timescale 1ns/1ps
// Matrix transfer link over a self-addressed UART frame: a TX matrix is sent as cell/row/column/matrix
// bursts; the RX side writes each frame into its own matrix. MATRIX_UART_LOOPBACK_EN feeds tx into the receiver.
module matrix_uart_link #(
  parameter int W    = 8,
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DIV  = 10,
  parameter int PAR  = 0,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [2:0]    action,
  output logic          tx,
  input  logic          rx,
  output logic          t_busy,
  output logic          r_busy,
  output logic [W-1:0]  t_cell,
  output logic [W-1:0]  r_cell,
  output logic          par_err,
  output logic          frm_err
);
  localparam int PB = CW + RW + W + ((PAR != 0) ? 1 : 0);
  localparam int NB = PB + 2;
  localparam int NR = 1 << RW;
  localparam int NC = 1 << CW;
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(PB);

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SHIFT} t_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} r_state_e;

  logic [W-1:0] t_mem [NR][NC];
  logic [W-1:0] r_mem [NR][NC];

  logic row_ok, col_ok, send_ok;
  assign row_ok = (32'(row) < ROWS);
  assign col_ok = (32'(col) < COLS);

  always_comb begin
    send_ok = 1'b0;
    case (action)
      3'd2:    send_ok = row_ok && col_ok;
      3'd3:    send_ok = row_ok;
      3'd4:    send_ok = col_ok;
      3'd5:    send_ok = 1'b1;
      default: send_ok = 1'b0;
    endcase
  end

  // ---------------- transmitter ----------------
  t_state_e      t_state, t_state_n;
  logic [2:0]    t_mode;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic [DW-1:0] t_div;
  logic [BW-1:0] t_bit;
  logic [NB-1:0] t_sh, frame_word;
  logic [W-1:0]  t_word;
  logic          t_div_end, frame_end, last_frame;

  assign t_word = t_mem[cur_row][cur_col];

  generate
    if (PAR != 0) begin : g_tx_par
      logic par_tx;
      assign par_tx     = (^{t_word, cur_row, cur_col}) ^ (PAR == 2);
      assign frame_word = {1'b1, par_tx, t_word, cur_row, cur_col, 1'b0};
    end else begin : g_tx_nopar
      assign frame_word = {1'b1, t_word, cur_row, cur_col, 1'b0};
    end
  endgenerate

  assign t_div_end = (t_div == DW'(DIV - 1));
  assign frame_end = (t_state == T_SHIFT) && t_div_end && (t_bit == BW'(NB - 1));

  always_comb begin
    last_frame = 1'b1;
    case (t_mode)
      3'd3:    last_frame = (cur_col == CW'(COLS - 1));
      3'd4:    last_frame = (cur_row == RW'(ROWS - 1));
      3'd5:    last_frame = (cur_col == CW'(COLS - 1)) && (cur_row == RW'(ROWS - 1));
      default: last_frame = 1'b1;
    endcase
  end

  always_comb begin
    t_state_n = t_state;
    case (t_state)
      T_IDLE:  if (send_ok) t_state_n = T_LOAD;
      T_LOAD:  t_state_n = T_SHIFT;
      T_SHIFT: if (frame_end) t_state_n = last_frame ? T_IDLE : T_LOAD;
      default: t_state_n = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) t_state <= T_IDLE;
    else     t_state <= t_state_n;
  end

  // LOAD already drives the first cycle of the start bit, so the DIV count resumes at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_mode  <= '0;
      cur_row <= '0;
      cur_col <= '0;
      t_div   <= '0;
      t_bit   <= '0;
      t_sh    <= '1;
    end else begin
      case (t_state)
        T_IDLE: if (send_ok) begin
          t_mode  <= action;
          cur_row <= (action == 3'd4 || action == 3'd5) ? '0 : row;
          cur_col <= (action == 3'd3 || action == 3'd5) ? '0 : col;
        end
        T_LOAD: begin
          t_sh  <= frame_word;
          t_div <= DW'(1);
          t_bit <= '0;
        end
        T_SHIFT: begin
          if (t_div_end) begin
            t_div <= '0;
            if (t_bit == BW'(NB - 1)) begin
              case (t_mode)
                3'd3: cur_col <= cur_col + 1'b1;
                3'd4: cur_row <= cur_row + 1'b1;
                3'd5: if (cur_col == CW'(COLS - 1)) begin
                  cur_col <= '0;
                  cur_row <= cur_row + 1'b1;
                end else begin
                  cur_col <= cur_col + 1'b1;
                end
                default: ;
              endcase
            end else begin
              t_sh  <= {1'b1, t_sh[NB-1:1]};
              t_bit <= t_bit + 1'b1;
            end
          end else begin
            t_div <= t_div + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      t_mem <= '{default: '0};
    else if (t_state == T_IDLE && action == 3'd1 && row_ok && col_ok)
      t_mem[row][col] <= d;
  end

  assign tx     = (t_state == T_SHIFT) ? t_sh[0] : (t_state != T_LOAD);
  assign t_busy = (t_state != T_IDLE);
  assign t_cell = (row_ok && col_ok) ? t_mem[row][col] : '0;

  // ---------------- receiver ----------------
  logic rx_in;
`ifdef MATRIX_UART_LOOPBACK_EN
  assign rx_in = tx | (rx & 1'b0);
`else
  assign rx_in = rx;
`endif

  r_state_e      r_state, r_state_n;
  logic          rx_s1, rx_s2, rx_q;
  logic [DW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [PB-1:0] r_sh;
  logic          r_cnt_end, r_half, stop_tick, par_ok, r_addr_ok;
  logic [CW-1:0] r_col_f;
  logic [RW-1:0] r_row_f;
  logic [W-1:0]  r_data_f;

  assign r_col_f   = r_sh[CW-1:0];
  assign r_row_f   = r_sh[CW+RW-1:CW];
  assign r_data_f  = r_sh[CW+RW+W-1:CW+RW];
  assign r_addr_ok = (32'(r_row_f) < ROWS) && (32'(r_col_f) < COLS);

  generate
    if (PAR != 0) begin : g_rx_par
      assign par_ok = (((^r_sh[PB-2:0]) ^ (PAR == 2)) == r_sh[PB-1]);
    end else begin : g_rx_nopar
      assign par_ok = 1'b1;
    end
  endgenerate

  assign r_cnt_end = (r_cnt == DW'(DIV - 1));
  assign r_half    = (r_cnt == DW'(DIV / 2 - 1));
  assign stop_tick = (r_state == R_STOP) && r_cnt_end;

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (rx_q && !rx_s2) r_state_n = R_START;
      R_START: if (r_half) r_state_n = rx_s2 ? R_IDLE : R_BITS;
      R_BITS:  if (r_cnt_end && r_idx == IW'(PB - 1)) r_state_n = R_STOP;
      R_STOP:  if (r_cnt_end) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_q    <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
      case (r_state)
        R_IDLE:  r_cnt <= '0;
        R_START: if (r_half) begin
          r_cnt <= '0;
          r_idx <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        R_BITS: if (r_cnt_end) begin
          r_cnt <= '0;
          r_sh  <= {rx_s2, r_sh[PB-1:1]};
          r_idx <= r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        R_STOP: r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
      if (stop_tick) begin
        if (!rx_s2)  frm_err <= 1'b1;
        if (!par_ok) par_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_mem <= '{default: '0};
    else if (stop_tick && rx_s2 && par_ok && r_addr_ok)
      r_mem[r_row_f][r_col_f] <= r_data_f;
  end

  assign r_busy = (r_state != R_IDLE);
  assign r_cell = (row_ok && col_ok) ? r_mem[row][col] : '0;

endmodule

// File: tb/tb_matrix_uart_link.sv
`timescale 1ns/1ps
// Self-checking bench for matrix_uart_link: randomized writes and bursts checked against array models.
module tb_matrix_uart_link;
  localparam int W    = 11;
  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int DIV  = 10;
  localparam int PAR  = 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int N    = RW + CW + W + 2 + ((PAR != 0) ? 1 : 0);
  localparam int FC   = N * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  d = '0;
  logic [RW-1:0] row = '0;
  logic [CW-1:0] col = '0;
  logic [2:0]    action = '0;
  logic          tx, rx, t_busy, r_busy, par_err, frm_err;
  logic [W-1:0]  t_cell, r_cell;
  logic          loop_en = 1'b1;
  logic          rx_drv = 1'b1;

  assign rx = loop_en ? tx : rx_drv;

  matrix_uart_link #(.W(W), .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .PAR(PAR)) dut (
    .clk(clk), .rst(rst), .d(d), .row(row), .col(col), .action(action),
    .tx(tx), .rx(rx), .t_busy(t_busy), .r_busy(r_busy),
    .t_cell(t_cell), .r_cell(r_cell), .par_err(par_err), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t_model [ROWS][COLS];
  int r_model [ROWS][COLS];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_cell(input int r, input int c, input int v);
    @(negedge clk);
    action = 3'd1; row = RW'(r); col = CW'(c); d = W'(v);
    @(negedge clk);
    action = 3'd0;
    t_model[r][c] = v;
  endtask

  // Issues one send action, times the burst and compares the whole RX matrix afterwards.
  task automatic send(input int act, input int r, input int c, input string tag);
    int frames, cnt, k;
    frames = (act == 2) ? 1 : (act == 3) ? COLS : (act == 4) ? ROWS : ROWS * COLS;
    @(negedge clk);
    action = 3'(act); row = RW'(r); col = CW'(c);
    @(posedge clk); #1;
    action = 3'd0;
    n_checks++;
    if (t_busy !== 1'b1 || tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: t_busy=%b tx=%b, required t_busy=1 tx=0", tag, t_busy, tx);
    end
    cnt = 1;
    for (int i = 0; i < frames * FC + 20; i++) begin
      @(posedge clk); #1;
      if (t_busy !== 1'b1) break;
      cnt++;
    end
    n_checks++;
    if (cnt != frames * FC) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d cycles, required %0d", tag, cnt, frames * FC);
    end
    repeat (3 * DIV) @(negedge clk);
    k = 0;
    while (r_busy === 1'b1 && k < FC) begin @(negedge clk); k++; end
    n_checks++;
    if (r_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rx_idle: r_busy=%b, required 0", tag, r_busy);
    end
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if ((act == 2 && rr == r && cc == c) || (act == 3 && rr == r) ||
            (act == 4 && cc == c) || act == 5)
          r_model[rr][cc] = t_model[rr][cc];
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++) begin
        @(negedge clk); row = RW'(rr); col = CW'(cc); #1;
        n_checks++;
        if (r_cell !== W'(r_model[rr][cc])) begin
          n_fail++;
          $display("FAIL %s_r_cell(%0d,%0d): got %0d, required %0d", tag, rr, cc, r_cell, r_model[rr][cc]);
        end
      end
    n_checks++;
    if (par_err !== 1'b0 || frm_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: par_err=%b frm_err=%b, required 0 0", tag, par_err, frm_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1 || t_busy !== 1'b0 || r_busy !== 1'b0 || par_err !== 1'b0 || frm_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: tx=%b t_busy=%b r_busy=%b par=%b frm=%b, required 1 0 0 0 0",
               tx, t_busy, r_busy, par_err, frm_err);
    end
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        t_model[r][c] = 0;
        r_model[r][c] = 0;
      end
  endtask

  task automatic test_write();
    for (int i = 0; i < ROWS * COLS; i++) write_cell(i / COLS, i % COLS, i + 1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk); row = RW'(r); col = CW'(c); #1;
        n_checks++;
        if (t_cell !== W'(r * COLS + c + 1) || r_cell !== '0) begin
          n_fail++;
          $display("FAIL write_cell(%0d,%0d): t_cell=%0d r_cell=%0d, required %0d 0",
                   r, c, t_cell, r_cell, r * COLS + c + 1);
        end
      end
  endtask

  task automatic test_send_cell();   send(2, 1, 3, "send_cell"); endtask
  task automatic test_send_row();    send(3, 0, 0, "send_row");  endtask

  task automatic test_send_column();
    write_cell(1, 2, 1365);
    write_cell(0, 2, 682);
    send(4, 0, 2, "send_column");
  endtask

  task automatic test_write_busy();
    int v;
    v = (t_model[1][1] + 1 + $urandom_range(0, 100)) % (1 << W);
    @(negedge clk);
    action = 3'd2; row = '0; col = '0;
    @(negedge clk);
    action = 3'd0;
    repeat (20) @(negedge clk);
    action = 3'd1; row = RW'(1); col = CW'(1); d = W'(v);
    repeat (10) @(negedge clk);
    action = 3'd0;
    for (int i = 0; i < FC + 20 && t_busy === 1'b1; i++) @(negedge clk);
    row = RW'(1); col = CW'(1); #1;
    n_checks++;
    if (t_cell !== W'(t_model[1][1])) begin
      n_fail++;
      $display("FAIL write_busy: t_cell=%0d, required %0d (write during burst must be ignored)",
               t_cell, t_model[1][1]);
    end
    r_model[0][0] = t_model[0][0];
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int r, c, gap, len;
    r = $urandom_range(0, ROWS - 1);
    c = $urandom_range(0, COLS - 1);
    write_cell(r, c, $urandom_range(0, (1 << W) - 1));
    @(negedge clk);
    action = 3'd2; row = RW'(r); col = CW'(c);
    @(posedge clk); #1;
    for (int i = 0; i < FC + 20 && t_busy === 1'b1; i++) begin @(posedge clk); #1; end
    gap = 0;
    while (t_busy !== 1'b1 && gap < 10) begin gap++; @(posedge clk); #1; end
    action = 3'd0;
    n_checks++;
    if (gap != 1) begin
      n_fail++;
      $display("FAIL back_to_back_gap: idle gap %0d cycles, required 1", gap);
    end
    len = 1;
    for (int i = 0; i < FC + 20; i++) begin
      @(posedge clk); #1;
      if (t_busy !== 1'b1) break;
      len++;
    end
    n_checks++;
    if (len != FC) begin
      n_fail++;
      $display("FAIL back_to_back_len: got %0d cycles, required %0d", len, FC);
    end
    repeat (3 * DIV) @(negedge clk);
    r_model[r][c] = t_model[r][c];
    row = RW'(r); col = CW'(c); #1;
    n_checks++;
    if (r_cell !== W'(r_model[r][c])) begin
      n_fail++;
      $display("FAIL back_to_back_rcell: got %0d, required %0d", r_cell, r_model[r][c]);
    end
  endtask

  task automatic test_random_matrix();
    for (int i = 0; i < 6; i++)
      write_cell($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), $urandom_range(0, (1 << W) - 1));
    send(5, 0, 0, "send_matrix");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk); row = RW'(r); col = CW'(c); #1;
        n_checks++;
        if (t_cell !== W'(t_model[r][c])) begin
          n_fail++;
          $display("FAIL random_t_cell(%0d,%0d): got %0d, required %0d", r, c, t_cell, t_model[r][c]);
        end
      end
  endtask

  task automatic drive_frame(input int r, input int c, input int v, input bit flip_par, input bit stop_bit);
    int bits[$];
    int p;
    p = ($countones(v) + $countones(r) + $countones(c)) % 2;
    if (PAR == 2) p = 1 - p;
    bits.push_back(0);
    for (int i = 0; i < CW; i++) bits.push_back((c >> i) & 1);
    for (int i = 0; i < RW; i++) bits.push_back((r >> i) & 1);
    for (int i = 0; i < W; i++)  bits.push_back((v >> i) & 1);
    if (PAR != 0) bits.push_back(flip_par ? 1 - p : p);
    bits.push_back(stop_bit ? 1 : 0);
    @(negedge clk);
    foreach (bits[i]) begin
      rx_drv = (bits[i] != 0);
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic test_errors();
    int v;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (5) @(negedge clk);
    v = (r_model[0][1] + 1 + $urandom_range(0, 100)) % (1 << W);
    drive_frame(0, 1, v, 1'b1, 1'b1);
    row = '0; col = CW'(1); #1;
    n_checks++;
    if (par_err !== 1'b1 || frm_err !== 1'b0 || r_cell !== W'(r_model[0][1])) begin
      n_fail++;
      $display("FAIL bad_parity: par_err=%b frm_err=%b r_cell=%0d, required 1 0 %0d",
               par_err, frm_err, r_cell, r_model[0][1]);
    end
    drive_frame(0, 1, v, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (frm_err !== 1'b1 || r_cell !== W'(r_model[0][1])) begin
      n_fail++;
      $display("FAIL bad_stop: frm_err=%b r_cell=%0d, required 1 %0d", frm_err, r_cell, r_model[0][1]);
    end
    drive_frame(0, 1, v, 1'b0, 1'b1);
    r_model[0][1] = v;
    #1;
    n_checks++;
    if (r_cell !== W'(v)) begin
      n_fail++;
      $display("FAIL good_frame_ext: r_cell=%0d, required %0d", r_cell, v);
    end
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lows;
    @(negedge clk);
    action = 3'd5;
    @(negedge clk);
    action = 3'd0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tx !== 1'b1 || t_busy !== 1'b0 || r_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: tx=%b t_busy=%b r_busy=%b, required 1 0 0", tx, t_busy, r_busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk); row = RW'(r); col = CW'(c); #1;
        n_checks++;
        if (t_cell !== '0 || r_cell !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_cell(%0d,%0d): t_cell=%0d r_cell=%0d, required 0 0", r, c, t_cell, r_cell);
        end
      end
    lows = 0;
    repeat (2 * FC) begin
      @(negedge clk);
      if (tx !== 1'b1 || t_busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows != 0 || par_err !== 1'b0 || frm_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d active cycles par=%b frm=%b, required 0 0 0", lows, par_err, frm_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_send_cell();
    test_send_row();
    test_send_column();
    test_write_busy();
    test_back_to_back();
    test_random_matrix();
`ifndef MATRIX_UART_LOOPBACK_EN
    test_errors();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
